// File: rtl/hist_buffer_dpram_pkg.sv
// Shared defaults and the port-B collision rule for the histogram bin RAM.
package hist_buffer_dpram_pkg;
  localparam int HB_AW = 14;
  localparam int HB_DW = 16;

  // Both ports writing one word: port A's data is stored and returned on both ports.
  function automatic logic hb_b_takes_a(input logic wren_a, input logic wren_b,
                                        input logic addr_eq);
    return wren_a & wren_b & addr_eq;
  endfunction
endpackage

// File: rtl/hist_buffer_port.sv
// Output slice of one RAM port: write-first bypass over the registered array word,
// with the visible output forced to zero asynchronously while reset is held.
module hist_buffer_port #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          i_wren,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_rd_word,
  output logic [DW-1:0] o_q
);
  logic          r_live;
  logic          r_byp;
  logic [DW-1:0] r_byp_data;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_live     <= 1'b0;
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_live     <= 1'b1;
      r_byp      <= i_wren;
      r_byp_data <= i_wdata;
    end
  end

  // The array word is registered without reset so the block RAM output register still maps.
  assign o_q = !r_live ? '0 : (r_byp ? r_byp_data : i_rd_word);
endmodule

// File: rtl/hist_buffer_dpram.sv
// True dual-port histogram bin RAM: 1-cycle registered reads, write-first per port,
// old data across ports, port A wins a same-address double write.
module hist_buffer_dpram
  import hist_buffer_dpram_pkg::*;
#(
  parameter int AW = HB_AW,
  parameter int DW = HB_DW
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [AW-1:0] address_a,
  input  logic [DW-1:0] data_a,
  input  logic          wren_a,
  output logic [DW-1:0] q_a,
  input  logic [AW-1:0] address_b,
  input  logic [DW-1:0] data_b,
  input  logic          wren_b,
  output logic [DW-1:0] q_b
);
  logic [DW-1:0] r_mem [0:2**AW-1];
  logic [DW-1:0] r_rd_a;
  logic [DW-1:0] r_rd_b;
  logic          w_b_takes_a;
  logic [DW-1:0] w_wdata_b;

  assign w_b_takes_a = hb_b_takes_a(wren_a, wren_b, address_a == address_b);
  assign w_wdata_b   = w_b_takes_a ? data_a : data_b;

  // Plain RAM core; port A's write is ordered last so it owns a shared address.
  always_ff @(posedge clock) begin
    r_rd_a <= r_mem[address_a];
    r_rd_b <= r_mem[address_b];
    if (!rst) begin
      if (wren_b) r_mem[address_b] <= data_b;
      if (wren_a) r_mem[address_a] <= data_a;
    end
  end

  hist_buffer_port #(.DW(DW)) u_port_a (
    .clock     (clock),
    .rst       (rst),
    .i_wren    (wren_a),
    .i_wdata   (data_a),
    .i_rd_word (r_rd_a),
    .o_q       (q_a)
  );

  hist_buffer_port #(.DW(DW)) u_port_b (
    .clock     (clock),
    .rst       (rst),
    .i_wren    (wren_b),
    .i_wdata   (w_wdata_b),
    .i_rd_word (r_rd_b),
    .o_q       (q_b)
  );
endmodule

// File: tb/tb_hist_buffer_dpram.sv
// Randomized check of hist_buffer_dpram against an array model plus directed corner cases.
module tb_hist_buffer_dpram;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [AW-1:0] address_a = '0, address_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          wren_a = 1'b0, wren_b = 1'b0;
  logic [DW-1:0] q_a, q_b;

  always #5 clock = ~clock;

  hist_buffer_dpram #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .rst(rst),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
  );

  logic [DW-1:0] mdl [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of traffic; expectations come from the model contents before the edge.
  task automatic step(input logic wa, input int aa, input logic [DW-1:0] da,
                      input logic wb, input int ab, input logic [DW-1:0] db);
    logic [DW-1:0] ea, eb;
    logic [AW-1:0] xa, xb;
    xa = AW'(aa);
    xb = AW'(ab);
    wren_a = wa; address_a = xa; data_a = da;
    wren_b = wb; address_b = xb; data_b = db;
    ea = wa ? da : mdl[xa];
    if (wb && wa && xa == xb) eb = da;
    else if (wb)              eb = db;
    else                      eb = mdl[xb];
    @(posedge clock); #1;
    if (wb) mdl[xb] = db;
    if (wa) mdl[xa] = da;
    chk($sformatf("q_a[%0d]", xa), q_a, ea);
    chk($sformatf("q_b[%0d]", xb), q_b, eb);
  endtask

  task automatic clear_all();
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, '0, 1'b1, i, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    int pix [4];
    foreach (mdl[i]) mdl[i] = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_q_a", q_a, '0);
    chk("reset_q_b", q_b, '0);
    rst = 1'b0;

    clear_all();

    step(1'b1, 3, 16'h00AA, 1'b0, 0, '0);
    step(1'b0, 0, '0, 1'b0, 3, '0);
    chk("basic_q_b", q_b, 16'h00AA);

    step(1'b1, 7, 16'h0055, 1'b0, 0, '0);
    chk("rdw_same_q_a", q_a, 16'h0055);

    step(1'b1, 9, 16'h0001, 1'b0, 0, '0);
    step(1'b1, 9, 16'h0002, 1'b0, 9, '0);
    chk("rdw_mixed_old", q_b, 16'h0001);
    step(1'b0, 0, '0, 1'b0, 9, '0);
    chk("rdw_mixed_new", q_b, 16'h0002);

    step(1'b1, 4, 16'h1111, 1'b1, 4, 16'h2222);
    chk("coll_q_a", q_a, 16'h1111);
    chk("coll_q_b", q_b, 16'h1111);
    step(1'b0, 4, '0, 1'b0, 4, '0);
    chk("coll_stored", q_b, 16'h1111);

    for (int n = 0; n < 400; n++) begin
      int aa, ab;
      aa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), aa, DW'($urandom),
           1'($urandom_range(0, 1)), ab, DW'($urandom));
    end

    // Asynchronous reset mid-run; contents must survive and writes must be ignored.
    step(1'b1, 5, 16'h1234, 1'b0, 0, '0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_q_a", q_a, '0);
    chk("rst_async_q_b", q_b, '0);
    wren_a = 1'b1; address_a = AW'(5); data_a = 16'hDEAD;
    wren_b = 1'b1; address_b = AW'(5); data_b = 16'hBEEF;
    @(posedge clock); #1;
    chk("rst_hold_q_a", q_a, '0);
    chk("rst_hold_q_b", q_b, '0);
    #1 rst = 1'b0;
    step(1'b0, 5, '0, 1'b0, 5, '0);
    chk("rst_kept", q_a, 16'h1234);

    // Histogram read-modify-write loop on port A, readout on port B.
    clear_all();
    pix = '{2, 2, 2, 5};
    foreach (pix[k]) begin
      step(1'b0, pix[k], '0, 1'b0, 0, '0);
      d = q_a + 1'b1;
      step(1'b1, pix[k], d, 1'b0, 0, '0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 0, '0, 1'b0, i, '0);
      if (i == 2) chk("hist_bin2", q_b, 16'd3);
      if (i == 5) chk("hist_bin5", q_b, 16'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
